onehot_rr_arbiter: RTL

Four-requester round-robin arbiter that shares a single downstream resource using a hardened one-hot state machine. Grants are registered and one-hot. A hold-time limit forces release from a stuck owner. Any illegal state encoding, or grant/state mismatch, is trapped, recovered to IDLE and reported through a sticky fault flag. It sits in front of the shared-resource FSMs in the CWE-1245 fixture set and serves as the "fixed" reference for gap-free, recoverable FSM design.

---
 rtl/onehot_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/onehot_rr_arbiter.sv
// Four-requester round-robin arbiter with a hardened one-hot FSM.
// Illegal state or grant encodings are trapped, recovered and flagged.
module onehot_rr_arbiter #(
    parameter logic [7:0] HOLD_MAX = 8'd8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic       fault_clr,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_GRANT   = 4'b0010,
        S_RELEASE = 4'b0100,
        S_RECOVER = 4'b1000
    } state_t;

    logic [3:0] state_q, state_n;
    logic [3:0] grant_q, grant_n;
    logic [1:0] owner_q, owner_n;
    logic [1:0] last_q, last_n;
    logic [7:0] cnt_q, cnt_n;
    logic       timeout_q, timeout_n;
    logic       fault_q, fault_n;
    logic       busy_q;

    logic       win_vld;
    logic [1:0] win;
    logic       st_legal;
    logic       gnt_multi;
    logic       detect;

    // Round-robin search: last+1 first, previous winner last.
    always_comb begin
        logic [1:0] idx;
        win_vld = 1'b0;
        win     = last_q;
        idx     = last_q;
        for (int i = 4; i >= 1; i--) begin
            idx = last_q + 2'(i);
            if (req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    // Consistency checks between state and grant registers.
    always_comb begin
        st_legal  = state_q inside {S_IDLE, S_GRANT, S_RELEASE, S_RECOVER};
        gnt_multi = (grant_q & (grant_q - 4'd1)) != 4'd0;
        detect    = !st_legal || gnt_multi
                 || (grant_q != 4'd0 && state_q != S_GRANT)
                 || (grant_q == 4'd0 && state_q == S_GRANT);
    end

    // Next-state and next-output logic; fault trap overrides all.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        owner_n   = owner_q;
        last_n    = last_q;
        cnt_n     = cnt_q;
        timeout_n = 1'b0;
        fault_n   = detect | (fault_q & ~fault_clr);
        if (detect) begin
            state_n = S_RECOVER;
            grant_n = 4'd0;
            cnt_n   = 8'd0;
        end else begin
            unique case (1'b1)
                state_q[0], state_q[2]: begin
                    if (win_vld) begin
                        state_n = S_GRANT;
                        grant_n = 4'd1 << win;
                        owner_n = win;
                        last_n  = win;
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = S_IDLE;
                        grant_n = 4'd0;
                    end
                end
                state_q[1]: begin
                    if (HOLD_MAX != 8'd0 && cnt_q == HOLD_MAX) begin
                        state_n   = S_RELEASE;
                        grant_n   = 4'd0;
                        timeout_n = 1'b1;
                    end else if (!req[owner_q]) begin
                        state_n = S_RELEASE;
                        grant_n = 4'd0;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_n = cnt_q + 8'd1;
                    end
                end
                state_q[3]: begin
                    state_n = S_IDLE;
                    grant_n = 4'd0;
                end
                default: begin
                    state_n = S_RECOVER;
                    grant_n = 4'd0;
                end
            endcase
        end
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            grant_q   <= 4'd0;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
            fault_q   <= fault_n;
            busy_q    <= (state_n == S_GRANT);
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule
